// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared fetch constants and state encoding
package wisc_pkg;

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    localparam logic [4:0]  OPC_HALT  = 5'b00000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [15:0] PC_INC    = 16'd2;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - 16-bit program counter with target load, increment and wrap detect
module pc_reg #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] target,
    input  logic        inc,
    output logic [15:0] pc,
    output logic [15:0] pc_next,
    output logic        wrap
);
    import wisc_pkg::*;

    logic carry;

    // Increment with carry-out so a wrap past 16'hFFFE is visible to the caller
    assign {carry, pc_next} = {1'b0, pc} + {1'b0, PC_INC};
    assign wrap = inc & carry;

    // Load wins over increment; loaded targets are forced to halfword alignment
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= {target[15:1], 1'b0};
        end else if (inc) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with redirect squash and decode hold
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = wisc_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirectTarget,
    input  logic        stallIn,
    input  logic        memStall,
    input  logic        memDone,
    input  logic [15:0] memData,
    output logic        memRd,
    output logic [15:0] memAddr,
    output logic [15:0] instr,
    output logic        instrValid,
    output logic [15:0] pcPlus2,
    output logic        err
);
    import wisc_pkg::*;

    fetch_state_t state;
    logic         squash;
    logic         pc_load;
    logic         pc_inc;
    logic         pc_wrap;
    logic [15:0]  pc;
    logic [15:0]  pc_next;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (pc_load),
        .target  (redirectTarget),
        .inc     (pc_inc),
        .pc      (pc),
        .pc_next (pc_next),
        .wrap    (pc_wrap)
    );

    // PC control: a redirect outside HALTED always wins; a kept fetch advances the PC
    always_comb begin
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        if (!rst && state != ST_HALTED && redirect) begin
            pc_load = 1'b1;
        end else if (!rst && state == ST_WAIT && memDone && !squash) begin
            pc_inc = 1'b1;
        end
    end

    assign memRd   = (state == ST_REQ) && !redirect && !rst;
    assign memAddr = pc;

    // Fetch FSM with registered decode-side outputs and sticky fault tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_REQ;
            squash     <= 1'b0;
            instr      <= NOP_INSTR;
            instrValid <= 1'b0;
            pcPlus2    <= 16'h0000;
            err        <= 1'b0;
        end else begin
            if (pc_wrap
                || (redirect && redirectTarget[0] && state != ST_HALTED)
                || (memDone && state != ST_WAIT)) begin
                err <= 1'b1;
            end
            case (state)
                ST_REQ: begin
                    if (!redirect && !memStall) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (memDone) begin
                        if (squash || redirect) begin
                            // The returning word belongs to a stale path
                            squash <= 1'b0;
                            state  <= ST_REQ;
                        end else begin
                            instr      <= memData;
                            instrValid <= 1'b1;
                            pcPlus2    <= pc_next;
                            state      <= ST_HOLD;
                        end
                    end else if (redirect) begin
                        squash <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        instr      <= NOP_INSTR;
                        instrValid <= 1'b0;
                        state      <= ST_REQ;
                    end else if (!stallIn) begin
                        instr      <= NOP_INSTR;
                        instrValid <= 1'b0;
                        state      <= (instr[15:11] == OPC_HALT) ? ST_HALTED : ST_REQ;
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [15:0] redirectTarget;
    logic        stallIn;
    logic        memStall;
    logic        memDone;
    logic [15:0] memData;
    logic        memRd;
    logic [15:0] memAddr;
    logic [15:0] instr;
    logic        instrValid;
    logic [15:0] pcPlus2;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    // expected {instr, pcPlus2} for every fetched word decode should consume
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirectTarget (redirectTarget),
        .stallIn        (stallIn),
        .memStall       (memStall),
        .memDone        (memDone),
        .memData        (memData),
        .memRd          (memRd),
        .memAddr        (memAddr),
        .instr          (instr),
        .instrValid     (instrValid),
        .pcPlus2        (pcPlus2),
        .err            (err)
    );

    // Decode-side consumer: pops the scoreboard whenever an instruction is taken
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && instrValid && !stallIn && !redirect) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL consume_unexpected: got instr=%h pcPlus2=%h, required no valid instruction", instr, pcPlus2);
            end else begin
                e = exp_q.pop_front();
                if (instr !== e[31:16] || pcPlus2 !== e[15:0]) begin
                    n_fail++;
                    $display("FAIL consume: got instr=%h pcPlus2=%h, required instr=%h pcPlus2=%h",
                             instr, pcPlus2, e[31:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one(input logic [15:0] addr, input logic [15:0] data);
        n_tests++;
        if (memRd !== 1'b1 || memAddr !== addr) begin
            n_fail++;
            $display("FAIL fetch_req: got memRd=%b memAddr=%h, required memRd=1 memAddr=%h", memRd, memAddr, addr);
        end
        step();
        n_tests++;
        if (memRd !== 1'b0 || instrValid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_wait: got memRd=%b instrValid=%b, required 0 0", memRd, instrValid);
        end
        memDone = 1'b1;
        memData = data;
        exp_q.push_back({data, addr + 16'd2});
        step();
        memDone = 1'b0;
        n_tests++;
        if (instrValid !== 1'b1 || instr !== data) begin
            n_fail++;
            $display("FAIL fetch_hold: got instrValid=%b instr=%h, required 1 %h", instrValid, instr, data);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_tests++;
        if (instrValid !== 1'b0 || instr !== 16'h0800 || pcPlus2 !== 16'h0000 || err !== 1'b0 || memRd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got v=%b instr=%h pc2=%h err=%b rd=%b, required 0 0800 0000 0 0",
                     instrValid, instr, pcPlus2, err, memRd);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_first_fetch();
        fetch_one(16'h0000, 16'hC005);
        n_tests++;
        if (memRd !== 1'b1 || memAddr !== 16'h0002) begin
            n_fail++;
            $display("FAIL first_next: got memRd=%b memAddr=%h, required 1 0002", memRd, memAddr);
        end
    endtask

    task automatic test_mem_stall();
        memStall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) memStall = 1'b0;
            #1;
            n_tests++;
            if (memRd !== 1'b1 || memAddr !== 16'h0002) begin
                n_fail++;
                $display("FAIL mem_stall_%0d: got memRd=%b memAddr=%h, required 1 0002", i, memRd, memAddr);
            end
            step();
        end
        n_tests++;
        if (memRd !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_stall_wait: got memRd=%b, required 0", memRd);
        end
        memDone = 1'b1;
        memData = 16'h1234;
        exp_q.push_back({16'h1234, 16'h0004});
        step();
        memDone = 1'b0;
        n_tests++;
        if (instrValid !== 1'b1 || instr !== 16'h1234) begin
            n_fail++;
            $display("FAIL mem_stall_hold: got v=%b instr=%h, required 1 1234", instrValid, instr);
        end
        step();
    endtask

    task automatic test_redirect_wait();
        n_tests++;
        if (memRd !== 1'b1 || memAddr !== 16'h0004) begin
            n_fail++;
            $display("FAIL redir_req: got memRd=%b memAddr=%h, required 1 0004", memRd, memAddr);
        end
        step();
        redirect = 1'b1;
        redirectTarget = 16'h0040;
        step();
        redirect = 1'b0;
        memDone = 1'b1;
        memData = 16'hBEEF;
        step();
        memDone = 1'b0;
        n_tests++;
        if (instrValid !== 1'b0 || instr !== 16'h0800 || memRd !== 1'b1 || memAddr !== 16'h0040) begin
            n_fail++;
            $display("FAIL redir_squash: got v=%b instr=%h rd=%b addr=%h, required 0 0800 1 0040",
                     instrValid, instr, memRd, memAddr);
        end
        fetch_one(16'h0040, 16'h2222);
    endtask

    task automatic test_stall_hold();
        stallIn = 1'b1;
        n_tests++;
        if (memRd !== 1'b1 || memAddr !== 16'h0042) begin
            n_fail++;
            $display("FAIL stall_req: got memRd=%b memAddr=%h, required 1 0042", memRd, memAddr);
        end
        step();
        memDone = 1'b1;
        memData = 16'h3333;
        exp_q.push_back({16'h3333, 16'h0044});
        step();
        memDone = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (instrValid !== 1'b1 || instr !== 16'h3333 || memRd !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got v=%b instr=%h rd=%b, required 1 3333 0", i, instrValid, instr, memRd);
            end
            step();
        end
        stallIn = 1'b0;
        #1;
        n_tests++;
        if (instrValid !== 1'b1 || memRd !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b rd=%b, required 1 0", instrValid, memRd);
        end
        step();
        n_tests++;
        if (memRd !== 1'b1 || memAddr !== 16'h0044) begin
            n_fail++;
            $display("FAIL stall_next: got memRd=%b memAddr=%h, required 1 0044", memRd, memAddr);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        a = 16'h0044;
        for (int i = 0; i < 3; i++) begin
            fetch_one(a, 16'hA001 + 16'(i));
            a = a + 16'd2;
        end
    endtask

    task automatic test_redirect_err();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pre: got err=%b, required 0", err);
        end
        redirect = 1'b1;
        redirectTarget = 16'h0051;
        #1;
        n_tests++;
        if (memRd !== 1'b0) begin
            n_fail++;
            $display("FAIL err_redir_rd: got memRd=%b, required 0", memRd);
        end
        step();
        redirect = 1'b0;
        #1;
        n_tests++;
        if (memAddr !== 16'h0050 || err !== 1'b1 || memRd !== 1'b1) begin
            n_fail++;
            $display("FAIL err_redir: got addr=%h err=%b rd=%b, required 0050 1 1", memAddr, err, memRd);
        end
        fetch_one(16'h0050, 16'h5555);
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b, required 1", err);
        end
    endtask

    task automatic test_halt();
        fetch_one(16'h0052, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (memRd !== 1'b0 || instrValid !== 1'b0) begin
                n_fail++;
                $display("FAIL halted_%0d: got rd=%b v=%b, required 0 0", i, memRd, instrValid);
            end
            step();
        end
        redirect = 1'b1;
        redirectTarget = 16'h0100;
        #1;
        step();
        redirect = 1'b0;
        step();
        n_tests++;
        if (memRd !== 1'b0 || memAddr !== 16'h0054) begin
            n_fail++;
            $display("FAIL halt_redirect: got rd=%b addr=%h, required 0 0054", memRd, memAddr);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_tests++;
        if (memRd !== 1'b1 || memAddr !== 16'h0000 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_restart: got rd=%b addr=%h err=%b, required 1 0000 0", memRd, memAddr, err);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirectTarget = 16'hFFFE;
        step();
        redirect = 1'b0;
        #1;
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_pre: got err=%b, required 0", err);
        end
        fetch_one(16'hFFFE, 16'h4000);
        n_tests++;
        if (err !== 1'b1 || memAddr !== 16'h0000 || memRd !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap: got err=%b addr=%h rd=%b, required 1 0000 1", err, memAddr, memRd);
        end
    endtask

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirectTarget = 16'h0000;
        stallIn = 1'b0;
        memStall = 1'b0;
        memDone = 1'b0;
        memData = 16'h0000;
        #1;
        test_reset();
        test_first_fetch();
        test_mem_stall();
        test_redirect_wait();
        test_stall_hold();
        test_back_to_back();
        test_redirect_err();
        test_halt();
        test_wrap();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
